mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register in the pipelined ARMv8 core.
- Converts the latched MemRead/MemWrite controls into a multi-cycle req/ack transaction on the data-memory port.
- Stalls the front of the pipeline until the transaction completes.
- Resolves branches (B, BR, CBZ, CBNZ) into pc_src/pc_target/flush and presents MEM/WB inputs.

Parameters:
- DATA_W, 64, data and address width
- REG_W, 5, destination register index width
- TIMEOUT_CYC, 16, cycles in BUSY without ack before a fault is declared

Ports:
- clock  in  1  clock
- reset  in  1  synchronous, active-high
- mem_read, mem_write, mem_to_reg  in  1 each  EX/MEM controls
- branch, uncond_branch, branch_reg, not_zero, zero  in  1 each  EX/MEM branch controls and ALU zero flag
- alu_result  in  DATA_W  effective address or ALU value
- store_data  in  DATA_W  read_data_2 from EX/MEM
- reg_target  in  DATA_W  read_data_1 from EX/MEM, BR target
- branch_target  in  DATA_W  PC-relative target from EX/MEM
- write_register  in  REG_W  destination register
- dmem_req  out  1  registered request
- dmem_we  out  1  registered write enable
- dmem_addr, dmem_wdata  out  DATA_W  registered address and write data
- dmem_ack  in  1  one-cycle completion pulse
- dmem_rdata  in  DATA_W  valid with dmem_ack
- stall  out  1  freezes PC, IF/ID, ID/EX, EX/MEM
- pc_src  out  1  take branch
- pc_target  out  DATA_W  redirect address
- flush  out  1  squash younger stages
- wb_data  out  DATA_W  MEM/WB data input
- wb_register  out  REG_W  MEM/WB destination
- wb_mem_to_reg  out  1  MEM/WB select
- mem_fault  out  1  one-cycle registered pulse

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clock.
- Reset values:
  - FSM = IDLE, timeout counter = 0, load buffer = 0.
  - dmem_req, dmem_we, dmem_addr, dmem_wdata and mem_fault all 0.
  - Combinational outputs follow their rules from that state.
- Access detection: access = mem_read | mem_write. aligned = (alu_result[2:0] == 0).
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If access, aligned, and not both read and write:
    - stall = 1 combinationally.
    - Next cycle: dmem_req = 1, dmem_we = mem_write, dmem_addr = alu_result, dmem_wdata = store_data; counter cleared; go to BUSY.
  - Otherwise stall = 0.
  - Misaligned access, or mem_read & mem_write both set: no request, stall = 0, mem_fault = 1 next cycle, wb_data = 0.
  - dmem_ack in IDLE is ignored (covers a stale ack after reset).
- BUSY:
  - stall = 1, dmem_req held at 1, counter increments each cycle.
  - On dmem_ack: capture dmem_rdata into load buffer, dmem_req = 0 next cycle, go to DONE.
  - Timeout: if counter == TIMEOUT_CYC-1 and no ack, load buffer = 0, mem_fault = 1 next cycle, dmem_req = 0, go to DONE.
  - Ack on the timeout cycle wins; no fault.
- DONE:
  - stall = 0; EX/MEM loads the next instruction at this clock edge.
  - wb_data = load buffer for a read, alu_result for a write.
  - Go to IDLE unconditionally, so the same instruction is never reissued.
- Latency:
  - Non-memory instruction: 0 added cycles.
  - Memory access: 2 + (cycles from request to ack) stall cycles. With ack in the first BUSY cycle, stall is high for 2 cycles.
- wb passthrough:
  - wb_data = alu_result in IDLE.
  - wb_register = write_register and wb_mem_to_reg = mem_to_reg, always; held stable by stall.
- Branch resolution:
  - take = uncond_branch | branch_reg | (branch & zero) | (not_zero & ~zero).
  - pc_src = take & ~stall; flush = pc_src.
  - pc_target = branch_reg ? reg_target : branch_target.
- Reset mid-transaction: abort immediately; dmem_req = 0 next cycle; no fault pulse.

Decomposition:
- Shared package holds:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - DATA_W and REG_W defaults.
  - Alignment mask constant 3'b111.
- One sub-module, branch_resolve: purely combinational; produces take, pc_target and flush.
- FSM, counter and memory registers stay in mem_access_unit.

Test Plan:
- Load: mem_read=1, alu_result=0x40, ack in the first BUSY cycle with rdata=0xDEADBEEF → stall high 2 cycles; dmem_addr=0x40, dmem_we=0; wb_data=0xDEADBEEF in DONE.
- Store: mem_write=1, alu_result=0x80, store_data=0x1234, ack after 3 cycles → dmem_we=1, dmem_wdata=0x1234; stall high 5 cycles; dmem_req drops the cycle after ack.
- Timeout: load with no ack, TIMEOUT_CYC=16 → mem_fault pulses once after 16 BUSY cycles; wb_data=0; FSM returns to IDLE.
- Misaligned and illegal: alu_result=0x43 with mem_read → no dmem_req, stall=0, mem_fault pulses; mem_read & mem_write both set → same response.
- Branches: branch=1, zero=1 → pc_src=1, pc_target=branch_target; not_zero=1, zero=1 → pc_src=0; branch_reg=1, reg_target=0x200 → pc_target=0x200; any branch asserted during stall → pc_src=0.
- Reset during BUSY → dmem_req=0 next cycle, no fault; a late ack in IDLE is ignored.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared types and constants for the MEM-stage access unit
package mem_access_unit_pkg;

  localparam int DATA_W_DEF      = 64;
  localparam int REG_W_DEF       = 5;
  localparam int TIMEOUT_CYC_DEF = 16;

  // Doubleword accesses must have the low three address bits clear.
  localparam logic [2:0] ALIGN_MASK = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mau_state_e;

  function automatic logic is_aligned(input logic [2:0] low_bits);
    return (low_bits & ALIGN_MASK) == 3'b000;
  endfunction

endpackage

// File: rtl/mem_access_unit_branch_resolve.sv
// rtl/mem_access_unit_branch_resolve.sv - combinational branch decision and redirect target
module branch_resolve #(
  parameter int DATA_W = 64
) (
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              branch_reg,
  input  logic              not_zero,
  input  logic              zero,
  input  logic              stall,
  input  logic [DATA_W-1:0] reg_target,
  input  logic [DATA_W-1:0] branch_target,
  output logic              take,
  output logic              flush,
  output logic [DATA_W-1:0] pc_target
);

  // A redirect is only honoured once the instruction is no longer held by a stall.
  always_comb begin
    take      = uncond_branch | branch_reg | (branch & zero) | (not_zero & ~zero);
    flush     = take & ~stall;
    pc_target = branch_reg ? reg_target : branch_target;
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: data-memory req/ack sequencing, stall and branch resolution
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_W       = REG_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_to_reg,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              branch_reg,
  input  logic              not_zero,
  input  logic              zero,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] reg_target,
  input  logic [DATA_W-1:0] branch_target,
  input  logic [REG_W-1:0]  write_register,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              stall,
  output logic              pc_src,
  output logic [DATA_W-1:0] pc_target,
  output logic              flush,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_register,
  output logic              wb_mem_to_reg,
  output logic              mem_fault
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  mau_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] load_buf_q, load_buf_d;
  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              fault_q, fault_d;

  logic              access;
  logic              legal;
  logic              take;

  // Classify the instruction sitting in EX/MEM.
  always_comb begin
    access = mem_read | mem_write;
    legal  = access & is_aligned(alu_result[2:0]) & ~(mem_read & mem_write);
  end

  // Transaction sequencing: next state, memory-port registers, stall and write-back data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    load_buf_d = load_buf_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    fault_d    = 1'b0;
    stall      = 1'b0;
    wb_data    = alu_result;

    unique case (state_q)
      ST_IDLE: begin
        // A stray ack here (e.g. left over from before a reset) is deliberately ignored.
        if (legal) begin
          stall   = 1'b1;
          req_d   = 1'b1;
          we_d    = mem_write;
          addr_d  = alu_result;
          wdata_d = store_data;
          cnt_d   = '0;
          state_d = ST_BUSY;
        end else if (access) begin
          fault_d = 1'b1;
          wb_data = '0;
        end
      end
      ST_BUSY: begin
        stall = 1'b1;
        cnt_d = cnt_q + CNT_W'(1);
        if (dmem_ack) begin
          // An ack arriving on the last allowed cycle still completes normally.
          load_buf_d = dmem_rdata;
          req_d      = 1'b0;
          state_d    = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          load_buf_d = '0;
          fault_d    = 1'b1;
          req_d      = 1'b0;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: begin
        // EX/MEM advances at this edge, so always leave DONE to avoid reissuing.
        wb_data = mem_read ? load_buf_q : alu_result;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and memory-port registers; reset aborts any transaction without a fault.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      load_buf_q <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      load_buf_q <= load_buf_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      fault_q    <= fault_d;
    end
  end

  // Drive the registered memory port and MEM/WB passthroughs.
  always_comb begin
    dmem_req      = req_q;
    dmem_we       = we_q;
    dmem_addr     = addr_q;
    dmem_wdata    = wdata_q;
    mem_fault     = fault_q;
    wb_register   = write_register;
    wb_mem_to_reg = mem_to_reg;
    pc_src        = flush;
  end

  branch_resolve #(
    .DATA_W(DATA_W)
  ) u_branch_resolve (
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .branch_reg    (branch_reg),
    .not_zero      (not_zero),
    .zero          (zero),
    .stall         (stall),
    .reg_target    (reg_target),
    .branch_target (branch_target),
    .take          (take),
    .flush         (flush),
    .pc_target     (pc_target)
  );

endmodule
